fpu_addsub_arbiter: RTL
=======================

Name: fpu_addsub_arbiter

Overview:
Shares one floating-point add/subtract core among N_REQ requesters. The block arbitrates round-robin, latches the granted operands and operation, and sequences the core: it pulses beg_FSM, waits for the core's ready, then pulses rst_FSM. The result is returned to the requester through a valid/ready response channel tagged with the requester ID. A watchdog aborts any operation in which the core never signals ready.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 32, operand/result width
ID_W, 2, requester ID width, clog2(N_REQ)
TIMEOUT, 64, maximum WAIT cycles before abort (1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req_valid_i  in  N_REQ  per-requester request valid
req_ready_o  out  N_REQ  per-requester accept, one-hot or zero
req_op_a_i  in  N_REQ*W  operand A, requester k at bits [k*W +: W]
req_op_b_i  in  N_REQ*W  operand B, packed the same way
req_sub_i  in  N_REQ  operation select, 1=subtract
core_beg_o  out  1  beg_FSM to core
core_rst_fsm_o  out  1  rst_FSM to core
core_op_a_o  out  W  latched operand A
core_op_b_o  out  W  latched operand B
core_sub_o  out  1  latched operation
core_ready_i  in  1  core ready flag
core_result_i  in  W  core final result
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accept
rsp_id_o  out  ID_W  requester ID of the response
rsp_result_o  out  W  result, zero on timeout
rsp_timeout_o  out  1  1 = operation aborted by watchdog
busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rr_ptr=0, timer=0. All outputs and all latched operand/result/ID registers are 0.
- States: IDLE, LAUNCH, WAIT, RELEASE, RESP.
- IDLE:
  - Grant g is the first index with req_valid_i high, searching from rr_ptr upward and wrapping modulo N_REQ.
  - req_ready_o[g]=1 combinationally; it is asserted only in IDLE.
  - On the handshake, latch op_a, op_b, sub and ID=g; set rr_ptr <= (g+1) mod N_REQ; go to LAUNCH.
  - If no request is valid, stay in IDLE and leave rr_ptr unchanged.
- LAUNCH: core_beg_o=1 for exactly one cycle; timer <= 0; go to WAIT.
- WAIT: timer increments each cycle.
  - If core_ready_i=1: latch core_result_i, set timeout flag=0, go to RELEASE.
  - Else if timer==TIMEOUT-1: result=0, set timeout flag=1, go to RELEASE.
  - If ready and timeout coincide, ready wins.
- RELEASE: core_rst_fsm_o=1 for one cycle; go to RESP. The pulse is also issued on timeout so the core returns to its start state.
- RESP: rsp_valid_o=1. rsp_id_o, rsp_result_o and rsp_timeout_o are held stable until rsp_ready_i=1, then go to IDLE.
- Operand stability: core_op_a_o, core_op_b_o and core_sub_o are registered. They are stable from LAUNCH until RESP exits and are not cleared between operations.
- core_ready_i is ignored in every state except WAIT.
- Latency: handshake at cycle 0; beg at cycle 1; WAIT starts at cycle 2. If ready is seen at cycle T, rst_FSM is at T+1 and rsp_valid_o at T+2. Minimum handshake-to-response is 4 cycles.
- One operation is in flight at a time. Requests are not accepted in any state other than IDLE, so an IDLE cycle always separates two operations, giving the core one cycle to reach its start state.
- A request withdrawn (valid dropped) before the handshake is simply not granted.
- Reset asserted mid-operation aborts immediately. No response is produced and core strobes drop low asynchronously.

Test Plan:
- Single request: req_valid_i=0001, A=0x3F800000, B=0x40000000, sub=0. Core ready returned 5 cycles after beg with result 0x40400000 → req_ready_o=0001 at cycle 0, beg at cycle 1, rst_FSM one cycle after ready, rsp_valid_o with id=0, result=0x40400000, timeout=0.
- Contention: req_valid_i=1111 held, rr_ptr=0 → grants in order 0,1,2,3,0. Each rsp_id_o matches its grant order. No requester is granted twice while another waits.
- Back-pressure: rsp_ready_i=0 for 10 cycles in RESP → rsp_valid_o and result held constant, req_ready_o=0, and the other requesters remain un-granted. Accepting the response returns the block to IDLE.
- Timeout: core_ready_i never asserted, TIMEOUT=64 → RELEASE after 64 WAIT cycles, with core_rst_fsm_o pulsed. Response has rsp_timeout_o=1 and result=0.
- Ready on the last WAIT cycle (timer=TIMEOUT-1) → result captured, rsp_timeout_o=0.
- Reset mid-WAIT: rst low for 1 cycle → busy_o=0, all outputs 0 immediately, rr_ptr=0. The next request from requester 2 is granted normally.

Source files
------------

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin front end for one shared FP add/sub core.
// A request is granted in IDLE and its operands are latched. The block then
// pulses beg_FSM, waits for the core's ready (bounded by a watchdog), pulses
// rst_FSM, and returns the result on a valid/ready response channel tagged
// with the ID of the requester that was granted.
module fpu_addsub_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 32,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid_i,
  output logic [N_REQ-1:0]   req_ready_o,
  input  logic [N_REQ*W-1:0] req_op_a_i,
  input  logic [N_REQ*W-1:0] req_op_b_i,
  input  logic [N_REQ-1:0]   req_sub_i,
  output logic               core_beg_o,
  output logic               core_rst_fsm_o,
  output logic [W-1:0]       core_op_a_o,
  output logic [W-1:0]       core_op_b_o,
  output logic               core_sub_o,
  input  logic               core_ready_i,
  input  logic [W-1:0]       core_result_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [ID_W-1:0]    rsp_id_o,
  output logic [W-1:0]       rsp_result_o,
  output logic               rsp_timeout_o,
  output logic               busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_RELEASE, S_RESP
  } state_t;

  state_t                    r_state, w_nxt;
  logic [ID_W-1:0]           r_rr_ptr;
  logic [7:0]                r_timer;
  logic [W-1:0]              r_op_a, r_op_b, r_result;
  logic                      r_sub, r_timeout;
  logic [ID_W-1:0]           r_id;

  // Per-requester operand views; element k is bits [k*W +: W].
  logic [N_REQ-1:0][W-1:0]   w_op_a, w_op_b;
  logic                      w_gnt_vld;
  logic [ID_W-1:0]           w_gnt_id;
  logic [N_REQ-1:0]          w_gnt_oh;
  logic                      w_to;

  assign w_op_a = req_op_a_i;
  assign w_op_b = req_op_b_i;
  assign w_to   = (r_timer == 8'(TIMEOUT-1));

  // Round-robin pick: walk offsets high-to-low so the nearest valid index
  // at or above rr_ptr is the last one written and therefore wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_gnt_oh  = '0;
    idx       = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      idx = ID_W'((int'(r_rr_ptr) + i) % N_REQ);
      if (req_valid_i[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = idx;
      end
    end
    if (w_gnt_vld) w_gnt_oh[w_gnt_id] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  // Next-state sequencing of the shared core.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_gnt_vld) w_nxt = S_LAUNCH;
      S_LAUNCH:  w_nxt = S_WAIT;
      S_WAIT:    if (core_ready_i || w_to) w_nxt = S_RELEASE;
      S_RELEASE: w_nxt = S_RESP;
      S_RESP:    if (rsp_ready_i) w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  // State-decoded strobes; accept is gated by reset so nothing handshakes
  // while the block is held in reset.
  always_comb begin
    req_ready_o    = (r_state == S_IDLE && rst) ? w_gnt_oh : '0;
    core_beg_o     = (r_state == S_LAUNCH);
    core_rst_fsm_o = (r_state == S_RELEASE);
    rsp_valid_o    = (r_state == S_RESP);
    busy_o         = (r_state != S_IDLE);
  end

  // Operand/result capture, watchdog timer and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr  <= '0;
      r_timer   <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_sub     <= 1'b0;
      r_id      <= '0;
      r_result  <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_gnt_vld) begin
          r_op_a   <= w_op_a[w_gnt_id];
          r_op_b   <= w_op_b[w_gnt_id];
          r_sub    <= req_sub_i[w_gnt_id];
          r_id     <= w_gnt_id;
          r_rr_ptr <= (w_gnt_id == ID_W'(N_REQ-1)) ? '0 : w_gnt_id + ID_W'(1);
        end
        S_LAUNCH: r_timer <= '0;
        S_WAIT: begin
          r_timer <= r_timer + 8'd1;
          // A ready on the final watchdog cycle still counts as success.
          if (core_ready_i) begin
            r_result  <= core_result_i;
            r_timeout <= 1'b0;
          end else if (w_to) begin
            r_result  <= '0;
            r_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_op_a_o   = r_op_a;
  assign core_op_b_o   = r_op_b;
  assign core_sub_o    = r_sub;
  assign rsp_id_o      = r_id;
  assign rsp_result_o  = r_result;
  assign rsp_timeout_o = r_timeout;

endmodule
